// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge.
// completion_entry_t is the record handed from the completion queue to the
// directory; resp_t / resp_worst() rank AXI responses by severity.
package apb2axi_pkg;

  localparam int TAG_NUM          = 8;
  localparam int TAG_W            = $clog2(TAG_NUM);
  localparam int BEAT_CNT_W       = 9;
  localparam int CQ_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [1:0]            resp;
    logic [BEAT_CNT_W-1:0] num_beats;
    logic                  error;
    logic [BEAT_CNT_W-1:0] err_beat_idx;
  } completion_entry_t;

  // Per-TAG running state while a transaction's beats are arriving.
  typedef struct packed {
    logic [BEAT_CNT_W-1:0] cnt;
    logic [1:0]            worst;
    logic                  err_seen;
    logic [BEAT_CNT_W-1:0] err_idx;
  } cq_acc_t;

  // Numeric ordering matches severity: OKAY < EXOKAY < SLVERR < DECERR.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apb2axi_cq_fifo.sv
// Synchronous FIFO of completion_entry_t with asynchronous active-low reset.
// Head is mem[rd_ptr], gated to zero while empty. A push while full is ignored.
// Handshake: push takes effect on a clock edge when push_vld=1 and level<DEPTH;
// pop takes effect on a clock edge when head_vld=1 and pop_rdy=1; the head
// holds steady while head_vld=1 and pop_rdy=0.
module apb2axi_cq_fifo
  import apb2axi_pkg::*;
#(
  parameter int DEPTH = CQ_DEPTH_DEFAULT
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic                       push_vld,
  input  completion_entry_t          push_entry,
  input  logic                       pop_rdy,
  output logic                       head_vld,
  output completion_entry_t          head_entry,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  completion_entry_t  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign head_vld   = (level != '0);
  assign head_entry = head_vld ? mem[rd_ptr] : '0;
  assign do_push    = push_vld && (level != LEVEL_W'(DEPTH));
  assign do_pop     = head_vld && pop_rdy;

  // Storage write; cleared on reset so the head reads zero after reset.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      level <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/apb2axi_cpl_queue.sv
// Completion queue: folds per-beat AXI responses into one completion per TAG
// and queues them for the directory.
// Optional feature macro: APB2AXI_CQ_STATS_EN builds the completion and error
// counters; without it both stat ports read zero.
// Handshake: a beat is taken on a clock edge when rsp_cq_beat_vld=1 and
// rsp_cq_beat_rdy=1; a completion leaves on a clock edge when cq_dir_cpl_vld=1
// and cq_dir_cpl_rdy=1, and the head stays stable while it waits.
module apb2axi_cpl_queue
  import apb2axi_pkg::*;
#(
  parameter int CQ_DEPTH = CQ_DEPTH_DEFAULT
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic                        rsp_cq_beat_vld,
  input  logic [TAG_W-1:0]            rsp_cq_beat_tag,
  input  logic [1:0]                  rsp_cq_beat_resp,
  input  logic                        rsp_cq_beat_last,
  output logic                        rsp_cq_beat_rdy,
  output logic                        cq_dir_cpl_vld,
  output completion_entry_t           cq_dir_cpl_entry,
  input  logic                        cq_dir_cpl_rdy,
  output logic [$clog2(CQ_DEPTH):0]   cq_level,
  output logic [15:0]                 cq_stat_cpl_cnt,
  output logic [15:0]                 cq_stat_err_cnt
);

  localparam int LEVEL_W = $clog2(CQ_DEPTH) + 1;

  cq_acc_t            acc_q [TAG_NUM];
  cq_acc_t            cur_acc;
  cq_acc_t            nxt_acc;
  logic               beat_acc;
  logic               cpl_push;
  completion_entry_t  cpl_entry;

  // Beats stall whenever the FIFO is full, even non-last ones, so beat order
  // per TAG is never disturbed.
  assign rsp_cq_beat_rdy = (cq_level != LEVEL_W'(CQ_DEPTH));
  assign beat_acc        = rsp_cq_beat_vld && rsp_cq_beat_rdy;
  assign cpl_push        = beat_acc && rsp_cq_beat_last;

  // Merge the incoming beat into its TAG's accumulator and build the completion.
  always_comb begin
    cur_acc   = acc_q[rsp_cq_beat_tag];
    nxt_acc   = cur_acc;
    cpl_entry = '0;
    nxt_acc.worst = resp_worst(cur_acc.worst, rsp_cq_beat_resp);
    if (rsp_cq_beat_resp[1] && !cur_acc.err_seen) begin
      nxt_acc.err_seen = 1'b1;
      nxt_acc.err_idx  = cur_acc.cnt;
    end
    // Saturate rather than wrap on over-long bursts.
    if (!(&cur_acc.cnt)) nxt_acc.cnt = cur_acc.cnt + 1'b1;
    cpl_entry.tag          = rsp_cq_beat_tag;
    cpl_entry.resp         = nxt_acc.worst;
    cpl_entry.num_beats    = cur_acc.cnt + 1'b1;
    cpl_entry.error        = nxt_acc.worst[1];
    cpl_entry.err_beat_idx = nxt_acc.err_seen ? nxt_acc.err_idx : '0;
  end

  // Accumulator update; the last beat clears its TAG in the same edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int t = 0; t < TAG_NUM; t++) acc_q[t] <= '0;
    end else if (beat_acc) begin
      if (rsp_cq_beat_last) acc_q[rsp_cq_beat_tag] <= '0;
      else                  acc_q[rsp_cq_beat_tag] <= nxt_acc;
    end
  end

  // A non-last beat arriving on a saturated counter means illegal traffic.
  cnt_no_saturate: assert property (@(posedge pclk) disable iff (!presetn)
    !(beat_acc && !rsp_cq_beat_last && (&cur_acc.cnt)));

  apb2axi_cq_fifo #(
    .DEPTH (CQ_DEPTH)
  ) u_fifo (
    .pclk       (pclk),
    .presetn    (presetn),
    .push_vld   (cpl_push),
    .push_entry (cpl_entry),
    .pop_rdy    (cq_dir_cpl_rdy),
    .head_vld   (cq_dir_cpl_vld),
    .head_entry (cq_dir_cpl_entry),
    .level      (cq_level)
  );

`ifdef APB2AXI_CQ_STATS_EN
  logic [15:0] stat_cpl_q;
  logic [15:0] stat_err_q;

  // Count every pushed completion and those carrying an error; wrap at 2^16.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      stat_cpl_q <= '0;
      stat_err_q <= '0;
    end else if (cpl_push) begin
      stat_cpl_q <= stat_cpl_q + 16'd1;
      if (cpl_entry.error) stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign cq_stat_cpl_cnt = stat_cpl_q;
  assign cq_stat_err_cnt = stat_err_q;
`else
  assign cq_stat_cpl_cnt = 16'h0;
  assign cq_stat_err_cnt = 16'h0;
`endif

endmodule
